// File: rtl/exposure_time_ctrl_pkg.sv
// Shared camera constants and exposure timer state encoding.
// Imported by exposure_time_ctrl and by the capture FSM.
package camera_pkg;

    localparam int EXP_W = 5;

    localparam logic [EXP_W-1:0] EXP_MIN   = 5'd2;
    localparam logic [EXP_W-1:0] EXP_MAX   = 5'd30;
    localparam logic [EXP_W-1:0] EXP_RESET = 5'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } tmr_state_e;

    // Saturating step; opposing requests cancel.
    function automatic logic [EXP_W-1:0] exp_step(
        input logic [EXP_W-1:0] t,
        input logic             up,
        input logic             dn
    );
        if (up && !dn && t < EXP_MAX) return t + EXP_W'(1);
        if (dn && !up && t > EXP_MIN) return t - EXP_W'(1);
        return t;
    endfunction

endpackage

// File: rtl/exposure_time_ctrl_if.sv
// Button, capture-FSM and exposure-result signals of exposure_time_ctrl.
// master = button panel / capture FSM side, slave = exposure_time_ctrl.
interface exposure_time_ctrl_if;
    import camera_pkg::*;

    logic             exp_increase;
    logic             exp_decrease;
    logic             init_btn;
    logic             busy;
    logic             expose;
    logic             init;
    logic [EXP_W-1:0] exp_time;
    logic             exp_done;

    modport master (
        output exp_increase, exp_decrease, init_btn, busy, expose,
        input  init, exp_time, exp_done
    );

    modport slave (
        input  exp_increase, exp_decrease, init_btn, busy, expose,
        output init, exp_time, exp_done
    );

endinterface

// File: rtl/exposure_time_ctrl_btn_edge.sv
// Button synchroniser, optional debounce and rising-edge pulse.
// Debounce filter is built only when BTN_DEBOUNCE_EN is defined.
module btn_edge
`ifdef BTN_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 8
)
`endif
(
    input  logic clk,
    input  logic RESET,
    input  logic btn_in,
    output logic pulse_out
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic lvl;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            prev_q  <= lvl;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_q;
    logic          db_d;

    // Level flips only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) db_d = sync2_q;
            else                             cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign lvl = db_q;
`else
    assign lvl = sync2_q;
`endif

    assign pulse_out = lvl & ~prev_q;

endmodule

// File: rtl/exposure_time_ctrl.sv
// Exposure-time register, init pulse and expose timer for the capture FSM.
// Define BTN_DEBOUNCE_EN to debounce the three push-buttons.
module exposure_time_ctrl
    import camera_pkg::*;
#(
    parameter int CLK_PER_MS = 1000,
    parameter int DB_CYCLES  = 8
) (
    input logic                 clk,
    input logic                 RESET,
    exposure_time_ctrl_if.slave bus
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic inc_p;
    logic dec_p;
    logic ini_p;

`ifdef BTN_DEBOUNCE_EN
    btn_edge #(.DB_CYCLES(DB_CYCLES)) u_inc (
        .clk(clk), .RESET(RESET), .btn_in(bus.exp_increase), .pulse_out(inc_p));
    btn_edge #(.DB_CYCLES(DB_CYCLES)) u_dec (
        .clk(clk), .RESET(RESET), .btn_in(bus.exp_decrease), .pulse_out(dec_p));
    btn_edge #(.DB_CYCLES(DB_CYCLES)) u_ini (
        .clk(clk), .RESET(RESET), .btn_in(bus.init_btn), .pulse_out(ini_p));
`else
    btn_edge u_inc (
        .clk(clk), .RESET(RESET), .btn_in(bus.exp_increase), .pulse_out(inc_p));
    btn_edge u_dec (
        .clk(clk), .RESET(RESET), .btn_in(bus.exp_decrease), .pulse_out(dec_p));
    btn_edge u_ini (
        .clk(clk), .RESET(RESET), .btn_in(bus.init_btn), .pulse_out(ini_p));
`endif

    logic [EXP_W-1:0] exp_time_q;
    logic [EXP_W-1:0] lat_q;
    logic [EXP_W-1:0] ms_q;
    logic [PW-1:0]    presc_q;
    logic             init_q;
    logic             expose_q;
    logic             rise;
    logic             wrap;
    logic             done;
    tmr_state_e       state_q;
    tmr_state_e       state_d;

    assign rise = bus.expose & ~expose_q;
    assign wrap = (presc_q == PW'(CLK_PER_MS - 1));

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            exp_time_q <= EXP_RESET;
            init_q     <= 1'b0;
            expose_q   <= 1'b0;
            lat_q      <= '0;
            ms_q       <= '0;
            presc_q    <= '0;
        end else begin
            expose_q <= bus.expose;
            init_q   <= ini_p & ~bus.busy;
            if (!bus.busy) exp_time_q <= exp_step(exp_time_q, inc_p, dec_p);
            if (state_q == IDLE && rise) begin
                lat_q   <= exp_time_q;
                ms_q    <= '0;
                presc_q <= '0;
            end else if (state_q == COUNT) begin
                if (wrap) begin
                    presc_q <= '0;
                    ms_q    <= ms_q + EXP_W'(1);
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Dropping expose aborts the count even on its final cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rise) state_d = COUNT;
            COUNT: begin
                if (!bus.expose)                         state_d = IDLE;
                else if (wrap && ms_q + EXP_W'(1) == lat_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == DONE);
    end

    assign bus.init     = init_q;
    assign bus.exp_time = exp_time_q;
    assign bus.exp_done = done;

endmodule
